dense_seq_argmax: RTL

Sequential, parametrised fully-connected layer engine for the hand-sign classifier datapath. It replaces the fully-unrolled combinational dense stage with one time-multiplexed signed MAC. Input activations and weights are read from synchronous memories; post-processed neuron outputs stream out over a valid/ready handshake. In final-layer use it also reports the winning class index, which provides the classifier's letter decision.

---
 rtl/dense_seq_argmax.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dense_seq_argmax.sv
// dense_seq_argmax
// Time-multiplexed fully-connected layer engine with argmax on the outputs.
// A single signed MAC walks every input activation for one output neuron,
// post-processes the sum (optional ReLU, arithmetic shift, saturation) and
// offers it on a valid/ready port. The running argmax over all accepted
// neuron values gives the classifier's winning class.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        begin an inference (only honoured while idle)
//   busy_o         inference in progress
//   in_addr_o      activation memory read address (data returns next cycle)
//   in_data_i      activation read data
//   w_addr_o       weight memory read address, row-major i*N_OUT + j
//   w_data_i       weight read data
//   out_valid_o    out_data_o / out_idx_o hold a neuron result
//   out_ready_i    consumer accepts the result when out_valid_o is high
//   out_data_o     post-processed neuron value
//   out_idx_o      neuron index of out_data_o
//   done_o         one-cycle pulse after the last neuron has been accepted
//   class_idx_o    index of the largest accepted neuron value
//   class_score_o  value of that neuron
module dense_seq_argmax #(
   parameter int IBW       = 8,
   parameter int KBW       = 13,
   parameter int N_IN      = 128,
   parameter int N_OUT     = 25,
   parameter int ACC_W     = 40,
   parameter int OBW       = 16,
   parameter int OUT_SHIFT = 0,
   parameter int RELU      = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   output logic                             busy_o,
   output logic [$clog2(N_IN)-1:0]          in_addr_o,
   input  logic signed [IBW-1:0]            in_data_i,
   output logic [$clog2(N_IN*N_OUT)-1:0]    w_addr_o,
   input  logic signed [KBW-1:0]            w_data_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic signed [OBW-1:0]            out_data_o,
   output logic [$clog2(N_OUT)-1:0]         out_idx_o,
   output logic                             done_o,
   output logic [$clog2(N_OUT)-1:0]         class_idx_o,
   output logic signed [OBW-1:0]            class_score_o
);

   localparam int IAW = $clog2(N_IN);
   localparam int WAW = $clog2(N_IN*N_OUT);
   localparam int JW  = $clog2(N_OUT);
   localparam int PW  = IBW + KBW;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;

   state_t                  state_q;
   logic [IAW-1:0]          inAddr_q;
   logic [WAW-1:0]          wAddr_q;
   logic [JW-1:0]           j_q;
   logic                    pend_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    busy_q;
   logic                    outValid_q;
   logic signed [OBW-1:0]   outData_q;
   logic [JW-1:0]           outIdx_q;
   logic                    done_q;
   logic [JW-1:0]           classIdx_q;
   logic signed [OBW-1:0]   classScore_q;

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] reluVal;
   logic signed [ACC_W-1:0] shiftVal;
   logic [ACC_W-OBW:0]      upperBits;
   logic signed [OBW-1:0]   satVal;

   // MAC datapath and post-processing. acc_d is the accumulator including the
   // product of the data pair that arrives this cycle; satVal is that sum
   // pushed through ReLU, the floor shift and the signed saturation.
   always_comb begin
      prod      = PW'(in_data_i) * PW'(w_data_i);
      acc_d     = acc_q + ACC_W'(prod);
      reluVal   = ((RELU != 0) && acc_d[ACC_W-1]) ? '0 : acc_d;
      shiftVal  = reluVal >>> OUT_SHIFT;
      // The value fits in OBW bits only if every bit above the OBW sign bit
      // is a copy of it.
      upperBits = shiftVal[ACC_W-1:OBW-1];
      if ((&upperBits) || !(|upperBits)) begin
         satVal = shiftVal[OBW-1:0];
      end else if (shiftVal[ACC_W-1]) begin
         satVal = {1'b1, {(OBW-1){1'b0}}};
      end else begin
         satVal = {1'b0, {(OBW-1){1'b1}}};
      end
   end

   // Control FSM with all outputs registered. pend_q marks that the memories
   // are returning data for an address issued in the previous cycle, so the
   // first RUN cycle of each neuron adds nothing and DRAIN adds the last
   // product. The weight address steps by N_OUT per activation and reloads
   // to the next column on neuron change, avoiding a multiplier.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         inAddr_q     <= '0;
         wAddr_q      <= '0;
         j_q          <= '0;
         pend_q       <= 1'b0;
         acc_q        <= '0;
         busy_q       <= 1'b0;
         outValid_q   <= 1'b0;
         outData_q    <= '0;
         outIdx_q     <= '0;
         done_q       <= 1'b0;
         classIdx_q   <= '0;
         classScore_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q      <= RUN;
                  inAddr_q     <= '0;
                  wAddr_q      <= '0;
                  j_q          <= '0;
                  pend_q       <= 1'b0;
                  acc_q        <= '0;
                  busy_q       <= 1'b1;
                  classIdx_q   <= '0;
                  classScore_q <= '0;
               end
            end
            RUN: begin
               if (pend_q) begin
                  acc_q <= acc_d;
               end
               pend_q <= 1'b1;
               if (inAddr_q == IAW'(N_IN-1)) begin
                  state_q <= DRAIN;
               end else begin
                  inAddr_q <= inAddr_q + IAW'(1);
                  wAddr_q  <= wAddr_q + WAW'(N_OUT);
               end
            end
            DRAIN: begin
               acc_q      <= acc_d;
               outData_q  <= satVal;
               outIdx_q   <= j_q;
               outValid_q <= 1'b1;
               state_q    <= EMIT;
            end
            EMIT: begin
               if (out_ready_i) begin
                  outValid_q <= 1'b0;
                  // Strictly greater keeps the lowest index on ties.
                  if ((j_q == '0) || (outData_q > classScore_q)) begin
                     classIdx_q   <= j_q;
                     classScore_q <= outData_q;
                  end
                  if (j_q == JW'(N_OUT-1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     j_q      <= j_q + JW'(1);
                     inAddr_q <= '0;
                     wAddr_q  <= WAW'(j_q) + WAW'(1);
                     acc_q    <= '0;
                     pend_q   <= 1'b0;
                     state_q  <= RUN;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign in_addr_o     = inAddr_q;
   assign w_addr_o      = wAddr_q;
   assign out_valid_o   = outValid_q;
   assign out_data_o    = outData_q;
   assign out_idx_o     = outIdx_q;
   assign done_o        = done_q;
   assign class_idx_o   = classIdx_q;
   assign class_score_o = classScore_q;

endmodule
